// File: rtl/color_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : color_slot_scheduler
//  Description : Cycles the red-pixel detector through Cr/Cb threshold slots,
//                one measurement per slot, and presents each centroid on a
//                valid/ready result channel.
//  Revision    : 1.0  initial release
// ============================================================================
module color_slot_scheduler #(
    parameter int NUM_SLOTS     = 4,
    parameter int SETTLE_FRAMES = 1
) (
    input  logic                 iVgaClk,
    input  logic                 reset_n,
    input  logic                 iVgaVRequest,
    input  logic                 iEnable,
    input  logic [NUM_SLOTS-1:0] iSlotMask,
    input  logic                 iCfgWrEn,
    input  logic [1:0]           iCfgSlot,
    input  logic [31:0]          iCfgData,
    input  logic [15:0]          iRedPixelHIndex,
    input  logic [15:0]          iRedPixelVIndex,
    output logic [7:0]           oCrLow,
    output logic [7:0]           oCrHigh,
    output logic [7:0]           oCbLow,
    output logic [7:0]           oCbHigh,
    output logic [1:0]           oSlot,
    output logic                 oResValid,
    input  logic                 iResReady,
    output logic [1:0]           oResSlot,
    output logic [15:0]          oResH,
    output logic [15:0]          oResV,
    output logic                 oBusy,
    output logic [7:0]           oDropCount
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETTLE  = 3'd1;
    localparam logic [2:0] c_ST_MEASURE = 3'd2;
    localparam logic [2:0] c_ST_PRESENT = 3'd3;
    localparam logic [2:0] c_ST_ADVANCE = 3'd4;

    localparam logic [31:0] c_RESET_ENTRY = 32'h00FF_00FF;
    localparam logic [3:0]  c_SETTLE_LOAD = 4'(SETTLE_FRAMES);

    logic [2:0]  r_state;
    logic        r_vreq_d;
    logic [3:0]  r_settle_cnt;
    logic [1:0]  r_slot;
    logic [31:0] r_thr;
    logic        r_res_valid;
    logic [1:0]  r_res_slot;
    logic [15:0] r_res_h;
    logic [15:0] r_res_v;
    logic [7:0]  r_drop;
    logic [31:0] r_table [NUM_SLOTS];

    logic        w_frame_end;
    logic        w_run;
    logic        w_cfg_in_range;
    logic [1:0]  w_first_slot;
    logic [1:0]  w_above_slot;
    logic        w_above_found;
    logic [1:0]  w_next_slot;
    logic        w_load;
    logic [1:0]  w_load_slot;

    assign w_frame_end    = r_vreq_d & ~iVgaVRequest;
    assign w_run          = iEnable & (|iSlotMask);
    assign w_cfg_in_range = (32'(iCfgSlot) < 32'(NUM_SLOTS));

    // Lowest set bit overall, and lowest set bit strictly above the current slot.
    always_comb begin
        w_first_slot  = 2'd0;
        w_above_slot  = 2'd0;
        w_above_found = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (iSlotMask[i]) begin
                w_first_slot = 2'(i);
                if (i > int'(r_slot)) begin
                    w_above_slot  = 2'(i);
                    w_above_found = 1'b1;
                end
            end
        end
        w_next_slot = w_above_found ? w_above_slot : w_first_slot;
    end

    always_comb begin
        w_load      = 1'b0;
        w_load_slot = w_first_slot;
        if (w_run && (r_state == c_ST_IDLE)) begin
            w_load = 1'b1;
        end else if (w_run && (r_state == c_ST_ADVANCE)) begin
            w_load      = 1'b1;
            w_load_slot = w_next_slot;
        end
    end

    // Table reads happen before the write lands, so a same-cycle load sees the old entry.
    always_ff @(posedge iVgaClk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_table[i] <= c_RESET_ENTRY;
            end
        end else if (iCfgWrEn && w_cfg_in_range) begin
            r_table[iCfgSlot] <= iCfgData;
        end
    end

    always_ff @(posedge iVgaClk) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_vreq_d     <= 1'b0;
            r_settle_cnt <= 4'd0;
            r_slot       <= 2'd0;
            r_thr        <= c_RESET_ENTRY;
            r_res_valid  <= 1'b0;
            r_res_slot   <= 2'd0;
            r_res_h      <= 16'd0;
            r_res_v      <= 16'd0;
            r_drop       <= 8'd0;
        end else begin
            r_vreq_d <= iVgaVRequest;
            if (w_load) begin
                r_slot       <= w_load_slot;
                r_thr        <= r_table[w_load_slot];
                r_settle_cnt <= c_SETTLE_LOAD;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_run) begin
                        r_state <= c_ST_SETTLE;
                    end
                end
                c_ST_SETTLE: begin
                    if (!w_run) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_frame_end) begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                        if (r_settle_cnt == 4'd1) begin
                            r_state <= c_ST_MEASURE;
                        end
                    end
                end
                c_ST_MEASURE: begin
                    if (!w_run) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_frame_end) begin
                        r_res_h     <= iRedPixelHIndex;
                        r_res_v     <= iRedPixelVIndex;
                        r_res_slot  <= r_slot;
                        r_res_valid <= 1'b1;
                        r_state     <= c_ST_PRESENT;
                    end
                end
                c_ST_PRESENT: begin
                    if (w_frame_end && (r_drop != 8'hFF)) begin
                        r_drop <= r_drop + 8'd1;
                    end
                    // The pending result always completes its handshake before leaving.
                    if (iResReady) begin
                        r_res_valid <= 1'b0;
                        r_state     <= w_run ? c_ST_ADVANCE : c_ST_IDLE;
                    end
                end
                c_ST_ADVANCE: begin
                    r_state <= w_run ? c_ST_SETTLE : c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign oCrLow     = r_thr[31:24];
    assign oCrHigh    = r_thr[23:16];
    assign oCbLow     = r_thr[15:8];
    assign oCbHigh    = r_thr[7:0];
    assign oSlot      = r_slot;
    assign oResValid  = r_res_valid;
    assign oResSlot   = r_res_slot;
    assign oResH      = r_res_h;
    assign oResV      = r_res_v;
    assign oBusy      = (r_state != c_ST_IDLE);
    assign oDropCount = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_color_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_color_slot_scheduler
//  Description : Vector table, directed corner sequences and random stimulus
//                against a frame-counting reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_color_slot_scheduler;

    localparam int SF = 1;
    localparam logic [31:0] RST_ENTRY = 32'h00FF_00FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vreq = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  mask = 4'd0;
    logic        ready = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  cslot = 2'd0;
    logic [31:0] cdata = 32'd0;
    logic [15:0] hidx = 16'd0;
    logic [15:0] vidx = 16'd0;

    logic [7:0]  crl, crh, cbl, cbh, drop;
    logic [1:0]  slot, rslot;
    logic        valid, busy;
    logic [15:0] resh, resv;

    int checks = 0;
    int errors = 0;

    color_slot_scheduler #(.NUM_SLOTS(4), .SETTLE_FRAMES(SF)) dut (
        .iVgaClk(clk), .reset_n(rst_n), .iVgaVRequest(vreq), .iEnable(en),
        .iSlotMask(mask), .iCfgWrEn(wr), .iCfgSlot(cslot), .iCfgData(cdata),
        .iRedPixelHIndex(hidx), .iRedPixelVIndex(vidx),
        .oCrLow(crl), .oCrHigh(crh), .oCbLow(cbl), .oCbHigh(cbh),
        .oSlot(slot), .oResValid(valid), .iResReady(ready), .oResSlot(rslot),
        .oResH(resh), .oResV(resv), .oBusy(busy), .oDropCount(drop)
    );

    always #5 clk = ~clk;

    // Reference model: a slot is "loaded", then the (SF+1)-th frame end yields a result.
    int          m_mode;   // 0 idle, 1 counting frames, 2 result pending, 3 reload due
    int          m_left;
    logic [1:0]  m_slot, m_rslot;
    logic [31:0] m_thr;
    logic [31:0] m_tab [4];
    logic        m_valid;
    logic [15:0] m_h, m_v;
    int          m_drop;
    logic        m_vprev;

    function automatic int lowest_from(logic [3:0] mk, int start);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (start + k) % 4;
            if (mk[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic void m_load(int s);
        m_slot = 2'(s);
        m_thr  = m_tab[s];
        m_left = SF + 1;
        m_mode = 1;
    endfunction

    function automatic void model_step();
        logic fe, run;
        fe  = m_vprev && !vreq;
        run = en && (mask != 4'd0);
        if (!rst_n) begin
            m_mode = 0; m_left = 0; m_slot = 0; m_rslot = 0; m_valid = 0;
            m_h = 0; m_v = 0; m_drop = 0; m_thr = RST_ENTRY; m_vprev = 0;
            for (int i = 0; i < 4; i++) m_tab[i] = RST_ENTRY;
            return;
        end
        m_vprev = vreq;
        case (m_mode)
            0: if (run) m_load(lowest_from(mask, 0));
            1: begin
                if (!run) m_mode = 0;
                else if (fe) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_h = hidx; m_v = vidx; m_rslot = m_slot; m_valid = 1; m_mode = 2;
                    end
                end
            end
            2: begin
                if (fe && m_drop < 255) m_drop++;
                if (ready) begin
                    m_valid = 0;
                    m_mode  = run ? 3 : 0;
                end
            end
            default: begin
                if (!run) m_mode = 0;
                else m_load(lowest_from(mask, int'(m_slot) + 1));
            end
        endcase
        if (wr) m_tab[cslot] = cdata;
    endfunction

    function automatic void chk(string name, logic [79:0] act, logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    bit model_on = 1'b0;

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (model_on)
            chk("model", {busy, slot, valid, rslot, resh, resv, drop, crl, crh, cbl, cbh},
                {1'(m_mode != 0), m_slot, m_valid, m_rslot, m_h, m_v, 8'(m_drop), m_thr});
    endtask

    task automatic frame();
        vreq = 1'b1; tick();
        vreq = 1'b0; tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rst_n, v, en;
        logic [3:0]  mask;
        logic        rdy, wr;
        logic [1:0]  cs;
        logic [31:0] cd;
        logic [15:0] h, vv;
        logic        e_busy;
        logic [1:0]  e_slot;
        logic        e_valid;
        logic [1:0]  e_rslot;
        logic [15:0] e_resh;
        logic [7:0]  e_drop;
        logic [31:0] e_thr;
    } vec_t;

    vec_t vecs [14];
    logic [1:0] seq [4];

    initial begin
        vecs[0]  = '{0,0,0,4'h0,0,0,0,32'h0,16'h0,16'h0,       0,0,0,0,16'h0,8'd0,32'h00FF00FF};
        vecs[1]  = '{1,1,0,4'h0,0,1,1,32'h90B06080,16'h0,16'h0, 0,0,0,0,16'h0,8'd0,32'h00FF00FF};
        vecs[2]  = '{1,1,1,4'h2,0,0,0,32'h0,16'h0,16'h0,       1,1,0,0,16'h0,8'd0,32'h90B06080};
        vecs[3]  = '{1,0,1,4'h2,0,0,0,32'h0,16'h0,16'h0,       1,1,0,0,16'h0,8'd0,32'h90B06080};
        vecs[4]  = '{1,1,1,4'h2,0,0,0,32'h0,16'h0,16'h0,       1,1,0,0,16'h0,8'd0,32'h90B06080};
        vecs[5]  = '{1,0,1,4'h2,0,0,0,32'h0,16'h0123,16'h0456, 1,1,1,1,16'h0123,8'd0,32'h90B06080};
        vecs[6]  = '{1,1,1,4'h2,0,0,0,32'h0,16'h0999,16'h0,    1,1,1,1,16'h0123,8'd0,32'h90B06080};
        vecs[7]  = '{1,0,1,4'h2,0,0,0,32'h0,16'h0999,16'h0,    1,1,1,1,16'h0123,8'd1,32'h90B06080};
        vecs[8]  = '{1,1,1,4'h2,1,0,0,32'h0,16'h0,16'h0,       1,1,0,1,16'h0123,8'd1,32'h90B06080};
        vecs[9]  = '{1,1,1,4'h2,0,0,0,32'h0,16'h0,16'h0,       1,1,0,1,16'h0123,8'd1,32'h90B06080};
        vecs[10] = '{1,1,0,4'h2,0,0,0,32'h0,16'h0,16'h0,       0,1,0,1,16'h0123,8'd1,32'h90B06080};
        vecs[11] = '{1,1,1,4'h2,0,1,1,32'hAABBCCDD,16'h0,16'h0, 1,1,0,1,16'h0123,8'd1,32'h90B06080};
        vecs[12] = '{1,1,0,4'h2,0,0,0,32'h0,16'h0,16'h0,       0,1,0,1,16'h0123,8'd1,32'h90B06080};
        vecs[13] = '{1,1,1,4'h2,0,0,0,32'h0,16'h0,16'h0,       1,1,0,1,16'h0123,8'd1,32'hAABBCCDD};

        for (int i = 0; i < 14; i++) begin
            rst_n = vecs[i].rst_n; vreq = vecs[i].v; en = vecs[i].en; mask = vecs[i].mask;
            ready = vecs[i].rdy; wr = vecs[i].wr; cslot = vecs[i].cs; cdata = vecs[i].cd;
            hidx = vecs[i].h; vidx = vecs[i].vv;
            tick();
            chk($sformatf("vec%0d", i), {busy, slot, valid, rslot, resh, drop, crl, crh, cbl, cbh},
                {vecs[i].e_busy, vecs[i].e_slot, vecs[i].e_valid, vecs[i].e_rslot,
                 vecs[i].e_resh, vecs[i].e_drop, vecs[i].e_thr});
        end
        wr = 1'b0;

        // Slot rotation with mask 0101: 0,2,0,2, result on the 2nd frame end after each load.
        en = 1'b0; vreq = 1'b1; do_reset();
        seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd0; seq[3] = 2'd2;
        en = 1'b1; mask = 4'b0101; ready = 1'b1; tick();
        chk("rot_first_slot", 80'(slot), 80'(seq[0]));
        for (int i = 0; i < 4; i++) begin
            frame();
            chk($sformatf("rot%0d_no_result_1st_fe", i), 80'(valid), 80'd0);
            frame();
            chk($sformatf("rot%0d_result_2nd_fe", i), {78'(rslot), 1'b0, valid}, {78'(seq[i]), 1'b0, 1'b1});
            vreq = 1'b1; tick();
            chk($sformatf("rot%0d_handshake", i), 80'(valid), 80'd0);
            tick();
            chk($sformatf("rot%0d_next_slot", i), 80'(slot), 80'(seq[(i + 1) % 4]));
        end

        // Backpressure across frame ends, then reset with a pending result.
        en = 1'b0; do_reset();
        wr = 1'b1; cslot = 2'd2; cdata = 32'h1122_3344; tick(); wr = 1'b0;
        en = 1'b1; mask = 4'b0100; ready = 1'b0; vreq = 1'b1; tick();
        chk("load_slot2_thr", {crl, crh, cbl, cbh}, 32'h1122_3344);
        frame();
        hidx = 16'h00AB; vidx = 16'h00CD; frame();
        chk("capture", {valid, resh, resv}, {1'b1, 16'h00AB, 16'h00CD});
        hidx = 16'h1111; vidx = 16'h2222;
        for (int i = 0; i < 3; i++) frame();
        chk("hold_3_drops", {valid, resh, resv, drop}, {1'b1, 16'h00AB, 16'h00CD, 8'd3});
        for (int i = 0; i < 4; i++) frame();
        chk("drop_7", 80'(drop), 80'd7);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("reset_all", {busy, slot, valid, rslot, resh, resv, drop, crl, crh, cbl, cbh},
            {1'b0, 2'd0, 1'b0, 2'd0, 16'd0, 16'd0, 8'd0, 32'h00FF00FF});

        // Enable dropped in settle, and in present.
        en = 1'b1; mask = 4'b0001; ready = 1'b0; vreq = 1'b1; tick();
        chk("settle_busy", 80'(busy), 80'd1);
        en = 1'b0; tick();
        chk("settle_abort", {busy, valid}, 2'b00);
        en = 1'b1; tick(); frame(); frame();
        chk("present_valid", 80'(valid), 80'd1);
        en = 1'b0; vreq = 1'b1; tick();
        chk("present_hold", {busy, valid}, 2'b11);
        ready = 1'b1; tick();
        chk("present_to_idle", {busy, valid}, 2'b00);

        // Random stimulus against the model.
        do_reset();
        model_on = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            vreq  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) mask = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 4) < 2);
            wr    = ($urandom_range(0, 9) == 0);
            cslot = 2'($urandom_range(0, 3));
            cdata = $urandom;
            hidx  = 16'($urandom);
            vidx  = 16'($urandom);
            tick();
        end
        model_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
